// File: rtl/fifo_width_down_pkg.sv
// rtl/fifo_width_down_pkg.sv - shared ratio/index helpers for the width-down drain stage
`ifndef FIFO_WIDTH_DOWN_PKG_SV
`define FIFO_WIDTH_DOWN_PKG_SV

// Elaboration guard: a word must split into a whole number of slices.
`define FWD_CHECK_DIVISIBLE(in_w, out_w) \
    if (((in_w) % (out_w)) != 0) begin : g_bad_ratio \
        $error("fifo_width_down: IN_WIDTH must be a multiple of OUT_WIDTH"); \
    end

package fifo_width_down_pkg;

    // Number of output slices per FIFO word.
    function automatic int calc_ratio(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    // Width of the slice counter; one bit minimum so RATIO=1 still has a register.
    function automatic int calc_idx_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    localparam int DEFAULT_IDX_W = calc_idx_w(calc_ratio(32, 8));

endpackage

`endif

// File: rtl/fifo_prefetch.sv
// rtl/fifo_prefetch.sv - read-strobe generation and two-entry word buffer in front of a 1-cycle-latency FIFO
module fifo_prefetch #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fifo_re,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic [WIDTH-1:0] word_data,
    output logic             word_valid,
    input  logic             word_ready
);

    logic             pending;
    logic             word_full;
    logic             next_full;
    logic [WIDTH-1:0] word_reg;
    logic [WIDTH-1:0] next_reg;
    logic             take;
    logic [1:0]       occ;
    logic [1:0]       occ_after;

    assign take      = word_full & word_ready;
    assign occ       = {1'b0, word_full} + {1'b0, next_full} + {1'b0, pending};
    assign occ_after = occ - {1'b0, take};

    // Issue a read only if the word it returns will have a free slot; a word
    // leaving this cycle frees one, so the stream never bubbles between words.
    always_comb begin
        fifo_re = ~rst & ~fifo_empty & (occ_after < 2'd2);
    end

    assign word_data  = word_reg;
    assign word_valid = word_full;

    // Capture returning read data into the active or prefetch slot and advance on take.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            word_full <= 1'b0;
            next_full <= 1'b0;
            word_reg  <= '0;
            next_reg  <= '0;
        end else begin
            pending <= fifo_re;
            if (pending) begin
                if (!word_full || (take && !next_full)) begin
                    word_reg  <= fifo_dout;
                    word_full <= 1'b1;
                end else if (take && next_full) begin
                    word_reg <= next_reg;
                    next_reg <= fifo_dout;
                end else begin
                    next_reg  <= fifo_dout;
                    next_full <= 1'b1;
                end
            end else if (take) begin
                if (next_full) begin
                    word_reg  <= next_reg;
                    next_full <= 1'b0;
                end else begin
                    word_full <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_width_down.sv
// rtl/fifo_width_down.sv - drains a wide FIFO and serializes each word into narrower valid/ready slices
import fifo_width_down_pkg::*;

module fifo_width_down #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 fifo_re,
    input  logic [IN_WIDTH-1:0]  fifo_dout,
    input  logic                 fifo_empty,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);

    `FWD_CHECK_DIVISIBLE(IN_WIDTH, OUT_WIDTH)

    localparam int RATIO = calc_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int IDX_W = calc_idx_w(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    logic [IN_WIDTH-1:0] word_data;
    logic                word_valid;
    logic [IDX_W-1:0]    slice_idx;
    logic [IDX_W-1:0]    slice_sel;
    logic [IN_WIDTH-1:0] shifted;
    logic                fire;
    logic                consume;

    fifo_prefetch #(
        .WIDTH (IN_WIDTH)
    ) u_prefetch (
        .clk        (clk),
        .rst        (rst),
        .fifo_re    (fifo_re),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (consume)
    );

    assign fire    = word_valid & out_ready;
    assign consume = fire & out_last;

    // Select the current slice; outputs read as zero whenever no word is held.
    always_comb begin
        slice_sel = (MSB_FIRST != 0) ? (LAST_IDX - slice_idx) : slice_idx;
        shifted   = word_data >> (32'(slice_sel) * 32'(OUT_WIDTH));
        out_data  = word_valid ? shifted[OUT_WIDTH-1:0] : '0;
        out_valid = word_valid;
        out_last  = word_valid & (slice_idx == LAST_IDX);
    end

    // Step through slices on each accepted beat and rewind when the word retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            slice_idx <= '0;
        end else if (consume) begin
            slice_idx <= '0;
        end else if (fire) begin
            slice_idx <= slice_idx + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_width_down.sv
// tb/tb_fifo_width_down.sv - directed self-checking bench for fifo_width_down
`timescale 1ns/1ps
module tb_fifo_width_down;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int bad_re   = 0;

    // Instance 0: defaults (32 -> 8, LSB first)
    logic        re0, empty0, v0, l0;
    logic        rdy0 = 1'b1;
    logic [31:0] dout0;
    logic [7:0]  od0;
    logic [31:0] mem0 [256];
    int          wr0 = 0;
    int          rd0 = 0;

    // Instance 1: 32 -> 8, MSB first
    logic        re1, empty1, v1, l1;
    logic        rdy1 = 1'b1;
    logic [31:0] dout1;
    logic [7:0]  od1;
    logic [31:0] mem1 [256];
    int          wr1 = 0;
    int          rd1 = 0;

    // Instance 2: 32 -> 32, MSB first
    logic        re2, empty2, v2, l2;
    logic        rdy2 = 1'b1;
    logic [31:0] dout2;
    logic [31:0] od2;
    logic [31:0] mem2 [256];
    int          wr2 = 0;
    int          rd2 = 0;

    assign empty0 = (wr0 == rd0);
    assign empty1 = (wr1 == rd1);
    assign empty2 = (wr2 == rd2);

    fifo_width_down #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(0)) u_dut0 (
        .clk(clk), .rst(rst), .fifo_re(re0), .fifo_dout(dout0), .fifo_empty(empty0),
        .out_data(od0), .out_valid(v0), .out_ready(rdy0), .out_last(l0));

    fifo_width_down #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1)) u_dut1 (
        .clk(clk), .rst(rst), .fifo_re(re1), .fifo_dout(dout1), .fifo_empty(empty1),
        .out_data(od1), .out_valid(v1), .out_ready(rdy1), .out_last(l1));

    fifo_width_down #(.IN_WIDTH(32), .OUT_WIDTH(32), .MSB_FIRST(1)) u_dut2 (
        .clk(clk), .rst(rst), .fifo_re(re2), .fifo_dout(dout2), .fifo_empty(empty2),
        .out_data(od2), .out_valid(v2), .out_ready(rdy2), .out_last(l2));

    // FIFO models with one-cycle read latency
    always @(posedge clk) begin
        if (re0) begin dout0 <= mem0[rd0[7:0]]; rd0 <= rd0 + 1; end
        if (re1) begin dout1 <= mem1[rd1[7:0]]; rd1 <= rd1 + 1; end
        if (re2) begin dout2 <= mem2[rd2[7:0]]; rd2 <= rd2 + 1; end
        if ((re0 && empty0) || (re1 && empty1) || (re2 && empty2)) bad_re <= bad_re + 1;
    end

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({re0, v0, l0, od0} !== 11'h0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got re=%b valid=%b last=%b data=%h expected all 0", i, re0, v0, l0, od0);
            end
            n_checks++;
            if ({re2, v2, l2} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_ratio1_outputs cycle %0d: got re=%b valid=%b last=%b expected 000", i, re2, v2, l2);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (re0 !== 1'b1) begin
            n_fail++;
            $display("FAIL first_re_after_reset: got %b expected 1", re0);
        end
    endtask

    task automatic test_single();
        logic [31:0] w;
        w = 32'hDDCCBBAA;
        @(negedge clk);
        n_checks++;
        if (v0 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency: got valid=%b expected 0 one cycle after re", v0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({v0, l0, od0} !== {1'b1, (i == 3), w[8*i +: 8]}) begin
                n_fail++;
                $display("FAIL single_slice%0d: got valid=%b last=%b data=%h expected valid=1 last=%b data=%h",
                         i, v0, l0, od0, (i == 3), w[8*i +: 8]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (v0 !== 1'b0 || rd0 !== 1) begin
            n_fail++;
            $display("FAIL single_end: got valid=%b reads=%0d expected valid=0 reads=1", v0, rd0);
        end
    endtask

    task automatic test_streaming();
        int base;
        base = rd0;
        for (int k = 0; k < 8; k++) begin
            mem0[wr0[7:0]] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            wr0 = wr0 + 1;
        end
        for (int c = 0; c < 10 && v0 !== 1'b1; c++) @(negedge clk);
        n_checks++;
        if (v0 !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_start: got valid=%b expected 1 within 10 cycles", v0);
            return;
        end
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if ({v0, l0, od0} !== {1'b1, ((i % 4) == 3), 8'(i)}) begin
                n_fail++;
                $display("FAIL stream_slice%0d: got valid=%b last=%b data=%h expected valid=1 last=%b data=%h",
                         i, v0, l0, od0, ((i % 4) == 3), 8'(i));
            end
            @(negedge clk);
        end
        n_checks++;
        if (v0 !== 1'b0 || (rd0 - base) !== 8) begin
            n_fail++;
            $display("FAIL stream_end: got valid=%b reads=%0d expected valid=0 reads=8", v0, rd0 - base);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] rx [16];
        int         got;
        int         stall_left;
        int         rd_at;
        logic [7:0] held;
        logic       held_last;
        got = 0;
        stall_left = -1;
        rd_at = rd0;
        held = '0;
        held_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem0[wr0[7:0]] = {8'(8'h43+4*k), 8'(8'h42+4*k), 8'(8'h41+4*k), 8'(8'h40+4*k)};
            wr0 = wr0 + 1;
        end
        rdy0 = 1'b1;
        for (int c = 0; c < 200 && got < 16; c++) begin
            @(negedge clk);
            if (stall_left > 0) begin
                n_checks++;
                if ({v0, l0, od0} !== {1'b1, held_last, held}) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%b last=%b data=%h expected valid=1 last=%b data=%h",
                             v0, l0, od0, held_last, held);
                end
                stall_left--;
            end
            if (got == 2 && stall_left < 0) begin
                stall_left = 10;
                held = od0;
                held_last = l0;
                rd_at = rd0;
            end
            rdy0 = (stall_left <= 0);
            if (v0 === 1'b1 && rdy0) begin
                rx[got] = od0;
                got++;
            end
        end
        rdy0 = 1'b1;
        n_checks++;
        if (got !== 16) begin
            n_fail++;
            $display("FAIL stall_count: got %0d slices expected 16", got);
        end
        for (int i = 0; i < got && i < 16; i++) begin
            n_checks++;
            if (rx[i] !== 8'(8'h40 + i)) begin
                n_fail++;
                $display("FAIL stall_order%0d: got %h expected %h", i, rx[i], 8'(8'h40 + i));
            end
        end
        n_checks++;
        if ((rd0 - rd_at) > 2) begin
            n_fail++;
            $display("FAIL stall_reads: got %0d reads after stall start expected at most 2", rd0 - rd_at);
        end
        @(negedge clk);
        n_checks++;
        if (v0 !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_drained: got valid=%b expected 0", v0);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] rx [4];
        logic       lx [4];
        logic [7:0] exp_b [4];
        int         n;
        exp_b[0] = 8'hDD; exp_b[1] = 8'hCC; exp_b[2] = 8'hBB; exp_b[3] = 8'hAA;
        n = 0;
        mem1[0] = 32'hDDCCBBAA;
        wr1 = 1;
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge clk);
            if (v1 === 1'b1) begin
                rx[n] = od1;
                lx[n] = l1;
                n++;
            end
        end
        n_checks++;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL msb4_count: got %0d slices expected 4", n);
        end
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if ({lx[i], rx[i]} !== {(i == 3), exp_b[i]}) begin
                n_fail++;
                $display("FAIL msb4_slice%0d: got last=%b data=%h expected last=%b data=%h",
                         i, lx[i], rx[i], (i == 3), exp_b[i]);
            end
        end

        mem2[0] = 32'h1; mem2[1] = 32'h2; mem2[2] = 32'h3;
        wr2 = 3;
        for (int c = 0; c < 10 && v2 !== 1'b1; c++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({v2, l2, od2} !== {1'b1, 1'b1, 32'(i + 1)}) begin
                n_fail++;
                $display("FAIL ratio1_word%0d: got valid=%b last=%b data=%h expected valid=1 last=1 data=%h",
                         i, v2, l2, od2, 32'(i + 1));
            end
            @(negedge clk);
        end
        n_checks++;
        if (v2 !== 1'b0) begin
            n_fail++;
            $display("FAIL ratio1_end: got valid=%b expected 0", v2);
        end
    endtask

    task automatic test_reset_mid_word();
        int base;
        base = rd0;
        for (int k = 0; k < 4; k++) begin
            mem0[wr0[7:0]] = {8'(8'h83+4*k), 8'(8'h82+4*k), 8'(8'h81+4*k), 8'(8'h80+4*k)};
            wr0 = wr0 + 1;
        end
        rdy0 = 1'b1;
        for (int c = 0; c < 10 && v0 !== 1'b1; c++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({v0, od0} !== {1'b1, 8'h82} || (rd0 - base) !== 2) begin
            n_fail++;
            $display("FAIL rst_mid_setup: got valid=%b data=%h reads=%0d expected valid=1 data=82 reads=2",
                     v0, od0, rd0 - base);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (re0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_forces_re: got %b expected 0", re0);
        end
        @(negedge clk);
        n_checks++;
        if ({re0, v0, l0, od0} !== 11'h0) begin
            n_fail++;
            $display("FAIL rst_mid_clear: got re=%b valid=%b last=%b data=%h expected all 0", re0, v0, l0, od0);
        end
        rst = 1'b0;
        for (int c = 0; c < 10 && v0 !== 1'b1; c++) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({v0, l0, od0} !== {1'b1, (i == 3), 8'(8'h88 + i)}) begin
                n_fail++;
                $display("FAIL rst_mid_resume%0d: got valid=%b last=%b data=%h expected valid=1 last=%b data=%h",
                         i, v0, l0, od0, (i == 3), 8'(8'h88 + i));
            end
            @(negedge clk);
        end
        for (int c = 0; c < 10; c++) @(negedge clk);
        n_checks++;
        if (v0 !== 1'b0 || rd0 !== wr0) begin
            n_fail++;
            $display("FAIL rst_mid_drain: got valid=%b unread=%0d expected valid=0 unread=0", v0, wr0 - rd0);
        end
    endtask

    task automatic test_no_read_when_empty();
        n_checks++;
        if (bad_re !== 0) begin
            n_fail++;
            $display("FAIL re_while_empty: got %0d strobes expected 0", bad_re);
        end
    endtask

    initial begin
        mem0[0] = 32'hDDCCBBAA;
        wr0 = 1;
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_msb_first();
        test_reset_mid_word();
        test_no_read_when_empty();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_width_down.md
# fifo_width_down

Downstream drain stage for the accelerator's synchronous `fifo`. It issues read strobes against the FIFO's one-cycle read latency, prefetches up to two words, and serializes each `IN_WIDTH` word into `RATIO = IN_WIDTH/OUT_WIDTH` narrower slices on a valid/ready stream. It sits between a result FIFO and the narrower output/host link, and sustains one slice per cycle with no bubbles between words.

## Interface
Parameters:
- `IN_WIDTH`, 32, FIFO word width; must equal the FIFO's `FIFO_WIDTH`.
- `OUT_WIDTH`, 8, output slice width. `IN_WIDTH % OUT_WIDTH == 0` is required; elaboration fails otherwise.
- `MSB_FIRST`, 0. 0 emits bits [OUT_WIDTH-1:0] first; 1 emits the top slice first.

Ports:
- Clock and reset:
  - `clk` in 1: single clock.
  - `rst` in 1: synchronous, active-high reset.
- FIFO side:
  - `fifo_re` out 1: read strobe to the FIFO.
  - `fifo_dout` in IN_WIDTH: FIFO read data, valid the cycle after `fifo_re`.
  - `fifo_empty` in 1: FIFO registered empty flag.
- Output stream:
  - `out_data` out OUT_WIDTH: current slice.
  - `out_valid` out 1: `out_data` is valid.
  - `out_ready` in 1: sink accepts the slice.
  - `out_last` out 1: the current slice is the final slice of its word.

## Operation
- State:
  - `pending`: a read was issued last cycle.
  - `word_reg`/`word_valid`: the active word.
  - `next_reg`/`next_valid`: the prefetched word.
  - `slice_idx`: 0..RATIO-1.
- Define `consume = out_valid & out_ready & out_last`.
- Define `occ = word_valid + next_valid + pending`.
- `fifo_re = ~fifo_empty & ((occ - consume) < 2)`. This is combinational from registers and `fifo_empty`.
  - `fifo_re` is never asserted while `fifo_empty` is high.
  - At most two words are ever owned or in flight.
- When `pending` is set, `fifo_dout` is captured at the clock edge:
  - If `word_valid`=0, or `consume` with `next_valid`=0: load into `word_reg`, set `slice_idx`=0.
  - If `consume` with `next_valid`=1: `word_reg<=next_reg`, `next_reg<=fifo_dout`.
  - Otherwise: load into `next_reg`.
- On `consume` with no capture: `next_reg` moves to `word_reg` if `next_valid`; otherwise `word_valid` clears. `slice_idx` resets to 0.
- On `out_valid & out_ready & ~out_last`: `slice_idx` increments.
- Output decode:
  - `out_valid = word_valid`.
  - `out_data` = slice `slice_idx` (or `RATIO-1-slice_idx` when `MSB_FIRST`=1).
  - `out_last = (slice_idx == RATIO-1)`.
- When RATIO=1, every slice is a last slice, and the stream runs at one word per cycle.

## Timing
- Reset values: `fifo_re`=0 (forced while `rst`), `out_valid`=0, `out_last`=0, `out_data`=0. All of `pending`, `word_valid`, `next_valid` and `slice_idx` clear to 0.
- Latency: `fifo_re` in cycle N → `fifo_dout` in N+1 → `out_valid` in N+2.
- Steady state with `out_ready`=1 and a non-empty FIFO: one slice per cycle, with `out_last` every RATIO cycles and no gap between words.
- Backpressure: while `out_valid & ~out_ready`, `out_data` and `out_last` hold stable. Reads stop once `occ`=2, and any in-flight word lands in `next_reg` without loss.
- FIFO running empty: `fifo_re` drops in the same cycle `fifo_empty` rises. `out_valid` falls after the last owned slice is consumed.
- Reset mid-word: all state clears on the next edge. Any in-flight or partially sent word is discarded, with no partial-word flush.
- `out_valid` does not depend combinationally on `out_ready`.

## Structure
- Shared package `fifo_width_down_pkg` holds:
  - the `RATIO` computation function;
  - the `clog2`-based `slice_idx` width constant;
  - the divisibility check macro.
- One sub-module is natural: `fifo_prefetch`. It covers `pending`, the two-entry `word`/`next` buffer and `fifo_re` generation, and presents an IN_WIDTH valid/ready word stream.
- The top level adds the slice counter and output mux.

## Test plan
- Reset: hold `rst` for 3 cycles with `fifo_empty`=0 → `fifo_re`=0, `out_valid`=0 and `out_data`=0 throughout; first `fifo_re` in the cycle after `rst` falls.
- Single word, defaults: FIFO holds 0xDDCCBBAA → slices AA, BB, CC, DD in 4 consecutive cycles. `out_last` only on DD. First `out_valid` 2 cycles after `fifo_re`.
- Streaming: 8 words with `out_ready`=1 → 32 slices in 32 consecutive cycles; exactly 8 `fifo_re` pulses; no bubble.
- Backpressure: `out_ready`=0 for 10 cycles mid-word → `out_data` stable; at most 2 `fifo_re` pulses in total after stall start; stream resumes in order with no duplicate or lost slice.
- MSB_FIRST=1 with RATIO=1 (OUT_WIDTH=32): words 0x1, 0x2, 0x3 → one word per cycle, `out_last`=1 on each. Separately, MSB_FIRST=1 with RATIO=4: 0xDDCCBBAA → DD, CC, BB, AA.
- Reset during slice 2 of a word with a second word in `next_reg` → outputs clear next cycle; after reset, the next FIFO word is emitted from slice 0.
